video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-mode video generator.
- Produces raster timing for any resolution: counters, sync, blanking, DE.
- Provides a runtime-selectable test-pattern source with programmable sync polarity and frame-synchronous mode switching.
- Sits between the pixel PLL and the scaler/VGA output of the SoC top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- CNT_W, 12, width of hcnt/vcnt; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pclk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- mode  in  2  pattern select: 0 bars, 1 grid, 2 gradient, 3 solid
- fill_rgb  in  24  solid colour {R,G,B}, used in mode 3
- hcnt  out  CNT_W  horizontal position of current output pixel
- vcnt  out  CNT_W  vertical position of current output pixel
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- VGA_HBLANK  out  1  high outside horizontal active region
- VGA_VBLANK  out  1  high outside vertical active region
- VGA_DE  out  1  ~VGA_HBLANK & ~VGA_VBLANK
- r, g, b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)
- frame_cnt  out  8  frames started since reset; wraps 255→0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter stage:
  - Internal h counts 0..H_TOTAL-1 then wraps to 0.
  - Internal v increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Output stage:
  - One registered stage. Every output, including hcnt/vcnt, describes the same pixel in the same cycle.
  - Total latency from counter to pins is 1 cycle. No output may be skewed relative to hcnt.
- Decode for pixel (h,v):
  - hblank = h ≥ H_ACTIVE.
  - vblank = v ≥ V_ACTIVE.
  - hs = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - vs transitions are line-aligned: they change on the same pixel as h=0.
- Reset:
  - While reset is high, all outputs are held at: hcnt=0, vcnt=0, hs=~HS_POL, vs=~VS_POL, VGA_HBLANK=1, VGA_VBLANK=1, VGA_DE=0, rgb=0, frame_start=0, frame_cnt=0, latched mode=0.
  - The internal counters are held at (0,0).
  - First cycle after reset falls: outputs still show the reset values.
  - Second cycle after reset falls: outputs present pixel (0,0) with frame_start=1, frame_cnt=1.
  - Reset asserted mid-frame takes effect on the next pclk edge and aborts the frame; there is no completion of the frame.
- Mode latch:
  - mode and fill_rgb are sampled only when the internal counters are at (0,0).
  - Changes mid-frame are invisible until the next frame.
- Patterns (active pixels only; rgb=0 whenever VGA_DE=0):
  - Mode 0, bars: 8 vertical bars of width BAR_W=H_ACTIVE/8. Bar index is tracked by an incremental bar counter, with no divider.
    - Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 0xFF or 0x00.
    - Pixels with h ≥ 8·BAR_W are black.
  - Mode 1, grid: white where h[3:0]==0 or v[3:0]==0, else black.
  - Mode 2, gradient: r=h[7:0], g=v[7:0], b=frame_cnt.
  - Mode 3, solid: {r,g,b}=latched fill_rgb.
- frame_cnt increments on the same cycle frame_start is high.
- Parameter legality is checked by elaboration-time assertions; behaviour with illegal parameters is undefined:
  - All porches and sync widths ≥ 1.
  - H_ACTIVE ≥ 8.
  - 2^CNT_W > max(H_TOTAL, V_TOTAL).

Decomposition:
- Package video_timing_pkg holds:
  - Pattern-mode enum (PAT_BARS, PAT_GRID, PAT_GRAD, PAT_SOLID).
  - The 8-entry bar-colour constant table.
  - A function computing totals and sync start/end from the parameters.
- One natural sub-module, video_pattern_gen: combinational colour from (h, v, latched mode, fill, frame_cnt, bar index).
  - Its result is registered in the parent.
- Counters, decode and the output register stay in video_timing_gen.

Test Plan:
All scenarios use small parameters: H 16/2/3/3 (H_TOTAL=24) and V 8/1/2/1 (V_TOTAL=12).
1. Release reset → frame_start on output cycle 2 with hcnt=0, vcnt=0, VGA_DE=1; next frame_start exactly 288 cycles later; frame_cnt=2.
2. Free-run one line → hs low for hcnt 18..20 only; VGA_HBLANK high for hcnt 16..23; VGA_DE high for exactly 16 cycles per active line.
3. Free-run one frame, then repeat with VS_POL=1 and HS_POL=1 → vs active for vcnt 9..10 (low in the first run, high in the second), edges at hcnt=0; with HS_POL=1 hs is high for hcnt 18..20.
4. mode=0 → hcnt 0..1 rgb=FFFFFF, hcnt 2..3 FFFF00, …, hcnt 14..15 000000; rgb=0 at hcnt 16..23.
5. Switch mode 3→2 at vcnt=4 with fill_rgb=123456 → rest of frame stays 123456; next frame at (5,3) gives r=05, g=03, b=frame_cnt.
6. Assert reset at (10,6) for 1 cycle → outputs hold reset values for 2 cycles, then frame_start with frame_cnt=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator and its pattern source.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] sync_start;
    logic [31:0] sync_end;
  } axis_t;

  function automatic axis_t axis_timing(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    axis_t a;
    a.total      = act + fp + sync + bp;
    a.sync_start = act + fp;
    a.sync_end   = act + fp + sync;
    return a;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern colour for one pixel; the parent registers the result.
module video_pattern_gen
  import video_timing_pkg::*;
(
  input  pat_mode_e   i_mode,
  input  logic [7:0]  i_h_lo,
  input  logic [7:0]  i_v_lo,
  input  logic [23:0] i_fill,
  input  logic [7:0]  i_frame_cnt,
  input  logic [3:0]  i_bar_idx,
  output logic [23:0] o_rgb
);

  always_comb begin
    o_rgb = '0;
    case (i_mode)
      // Bar index 8 marks the leftover pixels past the last full bar.
      PAT_BARS:  o_rgb = i_bar_idx[3] ? 24'h000000 : BAR_RGB[i_bar_idx[2:0]];
      PAT_GRID:  o_rgb = ((i_h_lo[3:0] == 4'd0) || (i_v_lo[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      PAT_GRAD:  o_rgb = {i_h_lo, i_v_lo, i_frame_cnt};
      PAT_SOLID: o_rgb = i_fill;
      default:   o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/blank/DE decode,
// frame-latched test pattern, all outputs aligned in a single register stage.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [23:0]      fill_rgb,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hs,
  output logic             vs,
  output logic             VGA_HBLANK,
  output logic             VGA_VBLANK,
  output logic             VGA_DE,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam axis_t H_T = axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam axis_t V_T = axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_T.total - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_T.total - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_T.sync_start);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_T.sync_end);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_T.sync_start);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_T.sync_end);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
    $error("video_timing_gen: porch and sync widths must be at least 1");
  end
  if (H_ACTIVE < 8) begin : g_chk_hact
    $error("video_timing_gen: H_ACTIVE must be at least 8");
  end
  if ((64'd1 << CNT_W) <= {32'd0, H_T.total} || (64'd1 << CNT_W) <= {32'd0, V_T.total}) begin : g_chk_cntw
    $error("video_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] r_h, r_v, r_bar_left;
  logic [3:0]       r_bar_idx;
  logic             r_hold;
  pat_mode_e        r_mode;
  logic [23:0]      r_fill;

  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic             r_hs, r_vs, r_hblank, r_vblank, r_de, r_fs;
  logic [23:0]      r_rgb;
  logic [7:0]       r_frame_cnt;

  logic             w_origin, w_h_wrap, w_v_wrap, w_hblank, w_vblank, w_de;
  pat_mode_e        w_mode;
  logic [23:0]      w_fill, w_rgb;
  logic [7:0]       w_fc_nxt;

  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_hblank = (r_h >= H_ACT_C);
  assign w_vblank = (r_v >= V_ACT_C);
  assign w_de     = ~w_hblank & ~w_vblank;

  // Pixel (0,0) already uses the freshly sampled mode/fill and the new frame count.
  assign w_mode   = w_origin ? pat_mode_e'(mode) : r_mode;
  assign w_fill   = w_origin ? fill_rgb : r_fill;
  assign w_fc_nxt = w_origin ? r_frame_cnt + 8'd1 : r_frame_cnt;

  // r_hold stretches reset by one cycle so the outputs show reset values twice.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_hold     <= 1'b1;
      r_h        <= '0;
      r_v        <= '0;
      r_bar_idx  <= '0;
      r_bar_left <= BAR_LAST;
      r_mode     <= PAT_BARS;
      r_fill     <= '0;
    end else if (r_hold) begin
      r_hold <= 1'b0;
    end else begin
      if (w_origin) begin
        r_mode <= w_mode;
        r_fill <= fill_rgb;
      end
      if (w_h_wrap) begin
        r_h        <= '0;
        r_v        <= w_v_wrap ? '0 : r_v + 1'b1;
        r_bar_idx  <= '0;
        r_bar_left <= BAR_LAST;
      end else begin
        r_h <= r_h + 1'b1;
        if (r_bar_left == '0) begin
          r_bar_left <= BAR_LAST;
          if (!r_bar_idx[3]) r_bar_idx <= r_bar_idx + 4'd1;
        end else begin
          r_bar_left <= r_bar_left - 1'b1;
        end
      end
    end
  end

  video_pattern_gen u_pattern (
    .i_mode      (w_mode),
    .i_h_lo      (8'(r_h)),
    .i_v_lo      (8'(r_v)),
    .i_fill      (w_fill),
    .i_frame_cnt (w_fc_nxt),
    .i_bar_idx   (r_bar_idx),
    .o_rgb       (w_rgb)
  );

  always_ff @(posedge pclk) begin
    if (reset || r_hold) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_hs        <= ~HS_POL;
      r_vs        <= ~VS_POL;
      r_hblank    <= 1'b1;
      r_vblank    <= 1'b1;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_fs        <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_hcnt      <= r_h;
      r_vcnt      <= r_v;
      r_hs        <= (r_h >= H_SS && r_h < H_SE) ? HS_POL : ~HS_POL;
      r_vs        <= (r_v >= V_SS && r_v < V_SE) ? VS_POL : ~VS_POL;
      r_hblank    <= w_hblank;
      r_vblank    <= w_vblank;
      r_de        <= w_de;
      r_rgb       <= w_de ? w_rgb : 24'h000000;
      r_fs        <= w_origin;
      r_frame_cnt <= w_fc_nxt;
    end
  end

  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign VGA_HBLANK  = r_hblank;
  assign VGA_VBLANK  = r_vblank;
  assign VGA_DE      = r_de;
  assign {r, g, b}   = r_rgb;
  assign frame_start = r_fs;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two polarity variants driven together, checked every
// cycle against a pixel-index reference model plus hand-computed spot values.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BW = HA / 8;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        hs, vs, hb, vb, de;
    logic [23:0] rgb;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  logic        pclk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [23:0] fill_rgb;

  logic [11:0] hcnt0, vcnt0, hcnt1, vcnt1;
  logic        hs0, vs0, hb0, vb0, de0, fs0, hs1, vs1, hb1, vb1, de1, fs1;
  logic [7:0]  r0, g0, b0, fc0, r1, g1, b1, fc1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 pclk = ~pclk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) dut0 (
    .pclk(pclk), .reset(reset), .mode(mode), .fill_rgb(fill_rgb),
    .hcnt(hcnt0), .vcnt(vcnt0), .hs(hs0), .vs(vs0),
    .VGA_HBLANK(hb0), .VGA_VBLANK(vb0), .VGA_DE(de0),
    .r(r0), .g(g0), .b(b0), .frame_start(fs0), .frame_cnt(fc0)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
  ) dut1 (
    .pclk(pclk), .reset(reset), .mode(mode), .fill_rgb(fill_rgb),
    .hcnt(hcnt1), .vcnt(vcnt1), .hs(hs1), .vs(vs1),
    .VGA_HBLANK(hb1), .VGA_VBLANK(vb1), .VGA_DE(de1),
    .r(r1), .g(g1), .b(b1), .frame_start(fs1), .frame_cnt(fc1)
  );

  out_t act0, act1, exp0, exp1;
  assign act0 = {hcnt0, vcnt0, hs0, vs0, hb0, vb0, de0, r0, g0, b0, fs0, fc0};
  assign act1 = {hcnt1, vcnt1, hs1, vs1, hb1, vb1, de1, r1, g1, b1, fs1, fc1};

  function automatic out_t rst_out(bit hp, bit vp);
    out_t o;
    o     = '0;
    o.hs  = ~hp;
    o.vs  = ~vp;
    o.hb  = 1'b1;
    o.vb  = 1'b1;
    return o;
  endfunction

  function automatic out_t pix(int h, int v, int md, logic [23:0] fill, logic [7:0] fc,
                               bit hp, bit vp);
    out_t o;
    o.hc  = h[11:0];
    o.vc  = v[11:0];
    o.hb  = (h >= HA);
    o.vb  = (v >= VA);
    o.de  = (h < HA) && (v < VA);
    o.hs  = (h >= HA + HF && h < HA + HF + HS) ? hp : ~hp;
    o.vs  = (v >= VA + VF && v < VA + VF + VS) ? vp : ~vp;
    o.rgb = 24'h0;
    if (o.de) begin
      case (md)
        0: o.rgb = (h / BW < 8) ? BARS[h / BW] : 24'h0;
        1: o.rgb = (h % 16 == 0 || v % 16 == 0) ? 24'hFFFFFF : 24'h0;
        2: o.rgb = {8'(h % 256), 8'(v % 256), fc};
        default: o.rgb = fill;
      endcase
    end
    o.fs  = (h == 0 && v == 0);
    o.fc  = fc;
    return o;
  endfunction

  // Model: pixel index within the frame since the last restart, plus a reset-hold count.
  bit          m_valid = 1'b0;
  int          m_hold  = 0;
  int          m_pos   = 0;
  int          m_mode  = 0;
  logic [23:0] m_fill  = '0;
  logic [7:0]  m_fc    = '0;

  always @(posedge pclk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_hold  = 1;
      m_pos   = 0;
      m_fc    = 8'd0;
      exp0    = rst_out(1'b0, 1'b0);
      exp1    = rst_out(1'b1, 1'b1);
    end else if (m_valid) begin
      if (m_hold > 0) begin
        m_hold = m_hold - 1;
        exp0   = rst_out(1'b0, 1'b0);
        exp1   = rst_out(1'b1, 1'b1);
      end else begin
        if (m_pos == 0) begin
          m_fc   = m_fc + 8'd1;
          m_mode = int'(mode);
          m_fill = fill_rgb;
        end
        exp0  = pix(m_pos % HT, m_pos / HT, m_mode, m_fill, m_fc, 1'b0, 1'b0);
        exp1  = pix(m_pos % HT, m_pos / HT, m_mode, m_fill, m_fc, 1'b1, 1'b1);
        m_pos = (m_pos + 1) % (HT * VT);
      end
    end
  end

  always @(negedge pclk) begin
    if (m_valid) begin
      n_checks++;
      if (act0 !== exp0) begin
        n_err++;
        $display("FAIL pix_pol0 t=%0t got %h expected %h", $time, act0, exp0);
      end
      n_checks++;
      if (act1 !== exp1) begin
        n_err++;
        $display("FAIL pix_pol1 t=%0t got %h expected %h", $time, act1, exp1);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, de_n, hb_n, hs0_n, hs1_n, hs0_min, hs0_max;
    int vs0_min, vs0_max, vs1_min, vs1_max, vs_edges, vs_bad;
    logic p_vs0, p_vs1;
    logic [23:0] line_rgb [HT];

    reset = 1'b1; mode = 2'd0; fill_rgb = 24'h0;
    repeat (3) @(negedge pclk);
    reset = 1'b0;

    @(negedge pclk);
    chk("hold_fs", fs0, 0);
    chk("hold_de", de0, 0);
    @(negedge pclk);
    chk("first_fs", fs0, 1);
    chk("first_hv", {hcnt0, vcnt0}, 0);
    chk("first_de", de0, 1);
    chk("first_fc", fc0, 1);

    cyc = 0;
    do begin @(negedge pclk); cyc++; end while (!fs0 && cyc < 400);
    chk("frame_period", cyc, HT * VT);
    chk("second_fc", fc0, 2);

    de_n = 0; hb_n = 0; hs0_n = 0; hs1_n = 0; hs0_min = 999; hs0_max = -1;
    for (int k = 0; k < HT; k++) begin
      line_rgb[k] = {r0, g0, b0};
      if (de0) de_n++;
      if (hb0) hb_n++;
      if (hs1) hs1_n++;
      if (!hs0) begin
        hs0_n++;
        if (int'(hcnt0) < hs0_min) hs0_min = int'(hcnt0);
        if (int'(hcnt0) > hs0_max) hs0_max = int'(hcnt0);
      end
      @(negedge pclk);
    end
    chk("line_de_cnt", de_n, 16);
    chk("line_hblank_cnt", hb_n, 8);
    chk("hs_low_cnt", hs0_n, 3);
    chk("hs_low_first", hs0_min, 18);
    chk("hs_low_last", hs0_max, 20);
    chk("hs_pol1_high_cnt", hs1_n, 3);
    chk("bar_h0", line_rgb[0], 24'hFFFFFF);
    chk("bar_h1", line_rgb[1], 24'hFFFFFF);
    chk("bar_h3", line_rgb[3], 24'hFFFF00);
    chk("bar_h4", line_rgb[4], 24'h00FFFF);
    chk("bar_h7", line_rgb[7], 24'h00FF00);
    chk("bar_h8", line_rgb[8], 24'hFF00FF);
    chk("bar_h10", line_rgb[10], 24'hFF0000);
    chk("bar_h13", line_rgb[13], 24'h0000FF);
    chk("bar_h14", line_rgb[14], 24'h000000);
    chk("blank_h16", line_rgb[16], 24'h000000);
    chk("blank_h23", line_rgb[23], 24'h000000);

    vs0_min = 999; vs0_max = -1; vs1_min = 999; vs1_max = -1; vs_edges = 0; vs_bad = 0;
    p_vs0 = vs0; p_vs1 = vs1;
    for (int k = 0; k < HT * VT; k++) begin
      if (!vs0) begin
        if (int'(vcnt0) < vs0_min) vs0_min = int'(vcnt0);
        if (int'(vcnt0) > vs0_max) vs0_max = int'(vcnt0);
      end
      if (vs1) begin
        if (int'(vcnt1) < vs1_min) vs1_min = int'(vcnt1);
        if (int'(vcnt1) > vs1_max) vs1_max = int'(vcnt1);
      end
      if (vs0 !== p_vs0) begin vs_edges++; if (hcnt0 != 12'd0) vs_bad++; end
      if (vs1 !== p_vs1) begin vs_edges++; if (hcnt1 != 12'd0) vs_bad++; end
      p_vs0 = vs0; p_vs1 = vs1;
      @(negedge pclk);
    end
    chk("vs_low_first", vs0_min, 9);
    chk("vs_low_last", vs0_max, 10);
    chk("vs_pol1_first", vs1_min, 9);
    chk("vs_pol1_last", vs1_max, 10);
    chk("vs_edge_cnt", vs_edges, 4);
    chk("vs_edge_off_h0", vs_bad, 0);

    mode = 2'd3; fill_rgb = 24'h123456;
    cyc = 0;
    while (!fs0 && cyc < 400) begin @(negedge pclk); cyc++; end
    chk("wait_fs_solid", fs0, 1);
    cyc = 0;
    while (vcnt0 != 12'd4 && cyc < 400) begin @(negedge pclk); cyc++; end
    mode = 2'd2; fill_rgb = 24'h000000;
    cyc = 0;
    while (!(vcnt0 == 12'd5 && hcnt0 == 12'd5) && cyc < 400) begin @(negedge pclk); cyc++; end
    chk("solid_held", {r0, g0, b0}, 24'h123456);
    cyc = 0;
    while (!fs0 && cyc < 400) begin @(negedge pclk); cyc++; end
    chk("wait_fs_grad", fs0, 1);
    cyc = 0;
    while (!(vcnt0 == 12'd3 && hcnt0 == 12'd5) && cyc < 400) begin @(negedge pclk); cyc++; end
    chk("grad_r", r0, 8'h05);
    chk("grad_g", g0, 8'h03);
    chk("grad_b", b0, 8'd5);

    cyc = 0;
    while (!(vcnt0 == 12'd6 && hcnt0 == 12'd10) && cyc < 400) begin @(negedge pclk); cyc++; end
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    chk("rst1_state", {hcnt0, vcnt0, de0, fs0, fc0, r0, g0, b0, hb0, vb0, hs0, vs0}, 64'hF);
    @(negedge pclk);
    chk("rst2_state", {hcnt0, vcnt0, de0, fs0, fc0, r0, g0, b0, hb0, vb0, hs0, vs0}, 64'hF);
    @(negedge pclk);
    chk("rst_restart_fs", fs0, 1);
    chk("rst_restart_fc", fc0, 1);
    chk("rst_restart_hv", {hcnt0, vcnt0}, 0);

    for (int i = 0; i < 6000; i++) begin
      @(negedge pclk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) fill_rgb = 24'($urandom);
    end
    reset = 1'b0;
    repeat (2) @(negedge pclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
